// File: rtl/io_mem_bridge.sv
// io_mem_bridge: CPU byte-bus decoder to RAM and MMIO (UART TX FIFO, RX handshake, cycle counter, halt flag).
// Define IO_TXCOUNT_EN to add a snapshotted counter of bytes sent to the UART at 0x30008-0x3000B.
module io_mem_bridge #(
    parameter int TX_ADDR_W  = 4,
    parameter int RAM_ADDR_W = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [31:0]           mem_a,
    input  logic [7:0]            mem_dout,
    input  logic                  mem_wr,
    output logic [7:0]            mem_din,
    output logic                  cpu_rdy,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  prog_halt
);
    localparam int D = 1 << TX_ADDR_W;

    logic [17:0]        off;
    logic               io, halt_wr, tx_wr, rx_rd, empty, full, pop, push, stall, acc;
    logic [TX_ADDR_W:0] wp_q, wp_d, rp_q, rp_d;
    logic [7:0]         fifo_q [D];
    logic [31:0]        cnt_q, snap_q, snap_d;
    logic [7:0]         io_rdata_q, io_rdata_d;
    logic               sel_io_q, halt_q, halt_d;
    logic               unused_hi;
`ifdef IO_TXCOUNT_EN
    logic [31:0]        txc_q, txsnap_q, txsnap_d;
`endif

    assign off       = mem_a[17:0];
    assign unused_hi = ^mem_a[31:18];
    assign io        = off[17:16] == 2'b11;
    assign halt_wr   = io & mem_wr & (off == 18'h30004);
    assign tx_wr     = halt_wr | (io & mem_wr & (off == 18'h30000) & (mem_dout != 8'h00));
    assign rx_rd     = io & ~mem_wr & (off == 18'h30000);
    assign empty     = wp_q == rp_q;
    assign full      = wp_q == {~rp_q[TX_ADDR_W], rp_q[TX_ADDR_W-1:0]};
    assign pop       = ~empty & tx_ready;
    // a pop in the same cycle frees the slot, so a full FIFO only stalls when the UART is not taking a byte
    assign stall     = (tx_wr & full & ~pop) | (rx_rd & ~rx_valid);
    assign cpu_rdy   = rst_in | ~stall;
    assign acc       = ~rst_in & ~stall;
    assign push      = acc & tx_wr;
    assign ram_en    = acc & ~io;
    assign ram_wr    = ram_en & mem_wr;
    assign ram_a     = mem_a[RAM_ADDR_W-1:0];
    assign ram_wdata = mem_dout;
    assign rx_ready  = acc & rx_rd;
    assign tx_valid  = ~empty;
    assign tx_data   = fifo_q[rp_q[TX_ADDR_W-1:0]];
    assign prog_halt = halt_q;
    assign mem_din   = sel_io_q ? io_rdata_q : ram_rdata;

    assign wp_d   = push ? wp_q + 1'b1 : wp_q;
    assign rp_d   = pop ? rp_q + 1'b1 : rp_q;
    assign halt_d = halt_q | (push & halt_wr);

    always_comb begin
        io_rdata_d = 8'h00;
        snap_d     = snap_q;
`ifdef IO_TXCOUNT_EN
        txsnap_d   = txsnap_q;
`endif
        if (off == 18'h30000) io_rdata_d = rx_data;
        else if (off == 18'h30004) begin
            io_rdata_d = cnt_q[7:0];
            snap_d     = cnt_q;
        end
        else if (off[17:2] == 16'hC001) io_rdata_d = snap_q[{off[1:0], 3'b000} +: 8];
`ifdef IO_TXCOUNT_EN
        else if (off == 18'h30008) begin
            io_rdata_d = txc_q[7:0];
            txsnap_d   = txc_q;
        end
        else if (off[17:2] == 16'hC002) io_rdata_d = txsnap_q[{off[1:0], 3'b000} +: 8];
`endif
    end

    always_ff @(posedge clk_in)
        if (push) fifo_q[wp_q[TX_ADDR_W-1:0]] <= halt_wr ? 8'h00 : mem_dout;

    // sel_io_q resets to 1 with io_rdata_q = 0 so mem_din reads 0 out of reset
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            snap_q     <= '0;
            io_rdata_q <= '0;
            sel_io_q   <= 1'b1;
            halt_q     <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_q + 32'd1;
            halt_q <= halt_d;
            if (acc) sel_io_q <= io;
            if (acc & io & ~mem_wr) begin
                io_rdata_q <= io_rdata_d;
                snap_q     <= snap_d;
            end
        end

`ifdef IO_TXCOUNT_EN
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            txc_q    <= '0;
            txsnap_q <= '0;
        end else begin
            txc_q <= txc_q + {31'd0, pop};
            if (acc & io & ~mem_wr) txsnap_q <= txsnap_d;
        end
`endif
endmodule

// File: tb/tb_io_mem_bridge.sv
// tb_io_mem_bridge: directed and randomized checks of io_mem_bridge against a queue/array reference model.
module tb_io_mem_bridge;
    logic        clk_in = 1'b0, rst_in = 1'b1;
    logic [31:0] mem_a = '0;
    logic [7:0]  mem_dout = '0, mem_din, ram_wdata, tx_data, ram_rdata = '0, rx_data = '0;
    logic        mem_wr = 1'b0, cpu_rdy, ram_en, ram_wr, tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready, prog_halt;
    logic [16:0] ram_a;

    int vec = 0, bad = 0;

    logic [7:0]  ram  [0:131071];
    logic [7:0]  mram [0:131071];
    logic [7:0]  txq[$], sent[$], got[$];
    logic [31:0] mcnt = 0, msnap = 0, mtxc = 0, mtsnap = 0;
    logic        mhalt = 0, din_chk = 0;
    logic [7:0]  exp_din = 0;
    logic [17:0] io_tab [9] = '{18'h30000, 18'h30004, 18'h30005, 18'h30006, 18'h30007,
                                18'h30008, 18'h30009, 18'h3000C, 18'h3ABCD};

    io_mem_bridge dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .cpu_rdy(cpu_rdy), .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .prog_halt(prog_halt)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) if (ram_en) begin
        if (ram_wr) ram[ram_a] <= ram_wdata;
        ram_rdata <= ram[ram_a];
    end

    always @(posedge clk_in) if (tx_valid && tx_ready) got.push_back(tx_data);

    function automatic logic is_io();
        return mem_a[17:16] == 2'b11;
    endfunction
    function automatic logic wants_push();
        return is_io() && mem_wr && ((mem_a[17:0] == 18'h30000 && mem_dout != 0) || mem_a[17:0] == 18'h30004);
    endfunction
    function automatic logic wants_rx();
        return is_io() && !mem_wr && mem_a[17:0] == 18'h30000;
    endfunction
    // The CPU waits only when a push meets 16 queued bytes the UART is not draining, or a RX read finds nothing.
    function automatic logic m_rdy();
        return !((wants_push() && txq.size() == 16 && !tx_ready) || (wants_rx() && !rx_valid));
    endfunction

    task automatic drv(input logic [31:0] a, input logic [7:0] d, input logic w);
        mem_a = a; mem_dout = d; mem_wr = w; #2;
    endtask

    task automatic tick();
        logic        ok = m_rdy();
        logic        pp = tx_ready && txq.size() != 0;
        logic [17:0] o = mem_a[17:0];
        logic [7:0]  rd = 0;
        logic [31:0] ns = msnap, nt = mtsnap;
        if (ok && !mem_wr) begin
            if (!is_io()) rd = mram[mem_a[16:0]];
            else if (o == 18'h30000) rd = rx_data;
            else if (o == 18'h30004) begin rd = mcnt[7:0]; ns = mcnt; end
            else if (o >= 18'h30005 && o <= 18'h30007) rd = 8'(msnap >> (8 * (o - 18'h30004)));
`ifdef IO_TXCOUNT_EN
            else if (o == 18'h30008) begin rd = mtxc[7:0]; nt = mtxc; end
            else if (o >= 18'h30009 && o <= 18'h3000B) rd = 8'(mtsnap >> (8 * (o - 18'h30008)));
`endif
        end
        @(posedge clk_in);
        if (pp) begin sent.push_back(txq.pop_front()); mtxc++; end
        if (ok) begin
            if (wants_push()) begin
                txq.push_back(o == 18'h30004 ? 8'h00 : mem_dout);
                if (o == 18'h30004) mhalt = 1;
            end
            if (!is_io() && mem_wr) mram[mem_a[16:0]] = mem_dout;
            din_chk = !mem_wr;
            if (!mem_wr) exp_din = rd;
            msnap = ns; mtsnap = nt;
        end
        mcnt++;
        #1;
    endtask

    task automatic rst_on();
        rst_in = 1; txq.delete(); sent.delete(); got.delete();
        mcnt = 0; msnap = 0; mtxc = 0; mtsnap = 0; mhalt = 0; din_chk = 0;
        #1;
    endtask

    task automatic rst_off();
        @(posedge clk_in); #1; rst_in = 0;
    endtask

    task automatic test_reset();
        rst_on();
        rx_valid = 0;
        drv(32'h0000_0123, 8'h11, 1);
        vec++; if (ram_en !== 1'b0) begin bad++; $display("FAIL reset_ram_en got %b want 0", ram_en); end
        vec++; if (ram_wr !== 1'b0) begin bad++; $display("FAIL reset_ram_wr got %b want 0", ram_wr); end
        drv(32'h0003_0000, 8'h00, 0);
        vec++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL reset_cpu_rdy got %b want 1", cpu_rdy); end
        vec++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
        vec++; if (mem_din !== 8'h00) begin bad++; $display("FAIL reset_mem_din got %h want 00", mem_din); end
        vec++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        vec++; if (prog_halt !== 1'b0) begin bad++; $display("FAIL reset_prog_halt got %b want 0", prog_halt); end
        rst_off();
        drv(32'h0, 8'h00, 0);
    endtask

    task automatic test_ram();
        drv(32'h0000_0123, 8'h5A, 1);
        vec++; if ({ram_en, ram_wr} !== 2'b11) begin bad++; $display("FAIL ram_wr_strobe got %b want 11", {ram_en, ram_wr}); end
        vec++; if (ram_a !== 17'h00123 || ram_wdata !== 8'h5A) begin bad++; $display("FAIL ram_wr_bus got %h/%h want 00123/5a", ram_a, ram_wdata); end
        tick();
        drv(32'hABC0_0123, 8'h00, 0);
        vec++; if ({ram_en, ram_wr} !== 2'b10) begin bad++; $display("FAIL ram_rd_strobe got %b want 10", {ram_en, ram_wr}); end
        tick();
        drv(32'h0000_0000, 8'h00, 0);
        vec++; if (mem_din !== 8'h5A) begin bad++; $display("FAIL ram_rd_data got %h want 5a", mem_din); end
        tick();
    endtask

    task automatic test_tx();
        logic [7:0] b [3] = '{8'h41, 8'h00, 8'h42};
        got.delete(); sent.delete(); tx_ready = 1;
        for (int i = 0; i < 3; i++) begin
            drv(32'h0003_0000, b[i], 1);
            vec++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL tx_rdy%0d got %b want 1", i, cpu_rdy); end
            tick();
        end
        drv(32'h0, 8'h00, 0);
        repeat (4) tick();
        vec++; if (got.size() !== 2) begin bad++; $display("FAIL tx_count got %0d want 2", got.size()); end
        else begin
            vec++; if (got[0] !== 8'h41 || got[1] !== 8'h42) begin bad++; $display("FAIL tx_bytes got %h %h want 41 42", got[0], got[1]); end
        end
    endtask

    task automatic test_tx_full();
        got.delete(); sent.delete(); tx_ready = 0;
        for (int i = 0; i < 16; i++) begin
            drv(32'h0003_0000, 8'(i + 1), 1);
            vec++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL fill_rdy%0d got %b want 1", i, cpu_rdy); end
            tick();
        end
        drv(32'h0003_0000, 8'd17, 1);
        vec++; if (cpu_rdy !== 1'b0) begin bad++; $display("FAIL full_stall got %b want 0", cpu_rdy); end
        tick();
        vec++; if (cpu_rdy !== 1'b0) begin bad++; $display("FAIL full_hold got %b want 0", cpu_rdy); end
        tx_ready = 1; #1;
        vec++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL full_release got %b want 1", cpu_rdy); end
        tick();
        drv(32'h0, 8'h00, 0);
        repeat (20) tick();
        vec++; if (got.size() !== 17) begin bad++; $display("FAIL full_count got %0d want 17", got.size()); end
        for (int i = 0; i < got.size() && i < 17; i++) begin
            vec++; if (got[i] !== 8'(i + 1)) begin bad++; $display("FAIL full_order%0d got %h want %h", i, got[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_rx();
        rx_valid = 0;
        drv(32'h0003_0000, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            vec++; if ({cpu_rdy, rx_ready} !== 2'b00) begin bad++; $display("FAIL rx_wait%0d got %b want 00", i, {cpu_rdy, rx_ready}); end
            tick();
        end
        rx_data = 8'h37; rx_valid = 1; #1;
        vec++; if ({cpu_rdy, rx_ready} !== 2'b11) begin bad++; $display("FAIL rx_take got %b want 11", {cpu_rdy, rx_ready}); end
        tick();
        rx_valid = 0; rx_data = 8'h99;
        drv(32'h0003_0010, 8'h00, 0);
        vec++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_pulse got %b want 0", rx_ready); end
        vec++; if (mem_din !== 8'h37) begin bad++; $display("FAIL rx_data got %h want 37", mem_din); end
        tick();
    endtask

    task automatic test_counter();
        logic [31:0] s;
        rst_on(); rst_off();
        drv(32'h0, 8'h00, 0);
        repeat (100) tick();
        for (int i = 4; i <= 8; i++) begin
            drv(i == 8 ? 32'h0 : 32'h0003_0000 + 32'(i), 8'h00, 0);
            if (i > 4) begin
                vec++; if (mem_din !== (i == 5 ? 8'h64 : 8'h00)) begin bad++; $display("FAIL snap_byte%0d got %h want %h", i - 5, mem_din, i == 5 ? 8'h64 : 8'h00); end
            end
            tick();
        end
        repeat (200) tick();
        s = mcnt;
        drv(32'h0003_0004, 8'h00, 0); tick();
        drv(32'h0003_0005, 8'h00, 0);
        vec++; if (mem_din !== s[7:0]) begin bad++; $display("FAIL cnt_lo got %h want %h", mem_din, s[7:0]); end
        tick();
        drv(32'h0, 8'h00, 0);
        vec++; if (mem_din !== s[15:8]) begin bad++; $display("FAIL cnt_b1 got %h want %h", mem_din, s[15:8]); end
        tick();
    endtask

    task automatic test_halt();
        got.delete(); sent.delete(); tx_ready = 0;
        for (int i = 0; i < 16; i++) begin drv(32'h0003_0000, 8'hA0 + 8'(i), 1); tick(); end
        drv(32'h0003_0004, 8'h77, 1);
        for (int i = 0; i < 3; i++) begin
            vec++; if ({cpu_rdy, prog_halt} !== 2'b00) begin bad++; $display("FAIL halt_wait%0d got %b want 00", i, {cpu_rdy, prog_halt}); end
            tick();
        end
        tx_ready = 1; #1;
        tick();
        drv(32'h0003_0000, 8'h55, 1);
        vec++; if (prog_halt !== 1'b1) begin bad++; $display("FAIL halt_set got %b want 1", prog_halt); end
        tick();
        drv(32'h0, 8'h00, 0);
        repeat (20) tick();
        vec++; if (got.size() !== 18 || got[16] !== 8'h00 || got[17] !== 8'h55) begin
            bad++; $display("FAIL halt_bytes got %0d bytes want 18 ending 00 55", got.size());
        end
        vec++; if (prog_halt !== 1'b1) begin bad++; $display("FAIL halt_sticky got %b want 1", prog_halt); end
    endtask

    task automatic test_reset_mid();
        tx_ready = 0;
        for (int i = 0; i < 3; i++) begin drv(32'h0003_0000, 8'h61, 1); tick(); end
        drv(32'h0003_0004, 8'h00, 0); tick();
        drv(32'h0003_0000, 8'h00, 0);
        rst_on();
        vec++; if ({tx_valid, prog_halt, cpu_rdy, rx_ready} !== 4'b0010) begin
            bad++; $display("FAIL rstmid_ctl got %b want 0010", {tx_valid, prog_halt, cpu_rdy, rx_ready});
        end
        vec++; if (mem_din !== 8'h00) begin bad++; $display("FAIL rstmid_din got %h want 00", mem_din); end
        rst_off();
        drv(32'h0, 8'h00, 0); tick();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        hold = 0;
        got.delete(); sent.delete();
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                int k = $urandom_range(0, 9);
                a = $urandom;
                if (k < 4) begin a[17:16] = 2'($urandom_range(0, 2)); a[15:6] = '0; end
                else a[17:0] = k < 7 ? 18'h30000 : io_tab[$urandom_range(0, 8)];
                drv(a, $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom), 1'($urandom_range(0, 1)));
            end
            tx_ready = n < 1500 ? $urandom_range(0, 9) == 0 : $urandom_range(0, 1) == 1;
            rx_valid = $urandom_range(0, 1) == 1;
            rx_data = 8'($urandom);
            #1;
            vec++; if (cpu_rdy !== m_rdy()) begin bad++; $display("FAIL rnd_rdy n=%0d got %b want %b", n, cpu_rdy, m_rdy()); end
            vec++; if (ram_en !== (m_rdy() && !is_io())) begin bad++; $display("FAIL rnd_ram_en n=%0d got %b", n, ram_en); end
            vec++; if (rx_ready !== (m_rdy() && wants_rx())) begin bad++; $display("FAIL rnd_rx_ready n=%0d got %b", n, rx_ready); end
            vec++; if (tx_valid !== (txq.size() != 0)) begin bad++; $display("FAIL rnd_tx_valid n=%0d got %b want %b", n, tx_valid, txq.size() != 0); end
            if (txq.size() != 0) begin
                vec++; if (tx_data !== txq[0]) begin bad++; $display("FAIL rnd_tx_data n=%0d got %h want %h", n, tx_data, txq[0]); end
            end
            vec++; if (prog_halt !== mhalt) begin bad++; $display("FAIL rnd_halt n=%0d got %b want %b", n, prog_halt, mhalt); end
            if (din_chk) begin
                vec++; if (mem_din !== exp_din) begin bad++; $display("FAIL rnd_din n=%0d got %h want %h", n, mem_din, exp_din); end
            end
            hold = !m_rdy();
            tick();
        end
        drv(32'h0, 8'h00, 0); tx_ready = 1;
        repeat (20) tick();
        vec++; if (got != sent) begin bad++; $display("FAIL rnd_stream got %0d bytes want %0d", got.size(), sent.size()); end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) begin ram[i] = 8'h00; mram[i] = 8'h00; end
        test_reset();
        test_ram();
        test_tx();
        test_tx_full();
        test_rx();
        test_counter();
        test_halt();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
